// File: rtl/cpu_step_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_controller_pkg
// Description : Shared types and constants for the CPU step controller and
//               its button debouncer. Holds the controller state encoding,
//               the step counter width, the board-clock default timing
//               constants and a counter-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_step_controller_pkg;

    // Controller states, explicitly 2 bits wide
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_STEP = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    // Width of the issued-pulse counter
    localparam int c_STEP_CNT_W = 16;

    // Defaults for the 100 MHz board clock: 10 ms debounce, 2 Hz run rate
    localparam int c_DEBOUNCE_CYCLES_DEFAULT = 1000000;
    localparam int c_RUN_DIV_DEFAULT         = 50000000;

    // Bits needed to hold 0..n-1; never narrower than one bit so that a
    // modulus of 1 still yields a legal vector.
    function automatic int ctrWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : cpu_step_controller_pkg
`default_nettype wire

// File: rtl/cpu_step_controller_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Two-flop synchronizer, counter-based debouncer and
//               rising-edge pulse generator for one mechanical button.
//               Reusable for any board push button.
// Ports       : clk         - board clock
//               rst         - synchronous active-high reset
//               i_btnRaw    - raw asynchronous, bouncing button level
//               o_stable    - debounced button level
//               o_risePulse - registered one-cycle pulse on a 0->1 change
//                             of o_stable
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer
    import cpu_step_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btnRaw,
    output logic o_stable,
    output logic o_risePulse
);

    localparam int                   c_CNT_W   = ctrWidth(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_risePulse;
    logic [c_CNT_W-1:0] r_cnt;

    // Counter would reach DEBOUNCE_CYCLES on this edge: accept the new level
    logic w_accept;
    assign w_accept = (r_sync2 != r_stable) && (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_stable    <= 1'b0;
            r_risePulse <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_sync1     <= i_btnRaw;
            r_sync2     <= r_sync1;
            // Pulse is generated on the same edge the stable level flips,
            // so it is visible in the first cycle with the new level.
            r_risePulse <= w_accept && r_sync2;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_stable    = r_stable;
    assign o_risePulse = r_risePulse;

endmodule : button_debouncer
`default_nettype wire

// File: rtl/cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : cpu_step_controller
// Description : Generates the one-cycle clock-enable for the single-cycle
//               RISC-V core. Single-steps on a debounced button press or
//               free-runs at a divided rate while the run switch is on.
//               Latches into HALT on the core's halt indication until reset.
// Ports       : clk        - board clock
//               rst        - synchronous active-high reset
//               btn_step   - raw step push button
//               sw_run     - raw run/step switch (1 = run)
//               halt       - core has reached ebreak/ecall
//               cpu_en     - registered one-cycle enable pulse to the core
//               step_count - number of cpu_en pulses since reset (wraps)
//               running    - high while in RUN
//               halted     - high while in HALT
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_step_controller
    import cpu_step_controller_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEFAULT,
    parameter int RUN_DIV         = c_RUN_DIV_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_step,
    input  logic                    sw_run,
    input  logic                    halt,
    output logic                    cpu_en,
    output logic [c_STEP_CNT_W-1:0] step_count,
    output logic                    running,
    output logic                    halted
);

    localparam int                 c_PRE_W   = ctrWidth(RUN_DIV);
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(RUN_DIV - 1);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic w_stepReq;
    logic w_btnStable;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_stepDebouncer (
        .clk         (clk),
        .rst         (rst),
        .i_btnRaw    (btn_step),
        .o_stable    (w_btnStable),
        .o_risePulse (w_stepReq)
    );

    // The slide switch does not bounce enough to matter at run rates, so it
    // is only synchronized.
    logic r_swSync1;
    logic r_swSync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_swSync1 <= 1'b0;
            r_swSync2 <= 1'b0;
        end else begin
            r_swSync1 <= sw_run;
            r_swSync2 <= r_swSync1;
        end
    end

    // ------------------------------------------------------------------
    // State machine: state register
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_nextState;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // State machine: next-state logic (halt > sw_run > step_req)
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (halt)           w_nextState = ST_HALT;
                else if (r_swSync2) w_nextState = ST_RUN;
                else if (w_stepReq) w_nextState = ST_STEP;
                else                w_nextState = ST_IDLE;
            end
            ST_STEP: begin
                if (halt)           w_nextState = ST_HALT;
                else if (r_swSync2) w_nextState = ST_RUN;
                else                w_nextState = ST_IDLE;
            end
            ST_RUN: begin
                // Step requests are dropped here rather than queued
                if (halt)            w_nextState = ST_HALT;
                else if (!r_swSync2) w_nextState = ST_IDLE;
                else                 w_nextState = ST_RUN;
            end
            ST_HALT: begin
                w_nextState = ST_HALT;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State machine: output logic (values loaded into the output flops)
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0] r_prescaler;
    logic [c_PRE_W-1:0] w_prescalerNext;
    logic               w_cpuEnNext;

    always_comb begin
        w_cpuEnNext     = 1'b0;
        w_prescalerNext = '0;
        // Entering STEP: the enable flop is high for the one STEP cycle
        if (w_nextState == ST_STEP) begin
            w_cpuEnNext = 1'b1;
        end
        // Prescaler only advances while staying in RUN; leaving RUN (to IDLE
        // or HALT) clears it and drops any terminal-count pulse.
        if ((r_state == ST_RUN) && (w_nextState == ST_RUN)) begin
            if (r_prescaler == c_PRE_MAX) begin
                w_cpuEnNext     = 1'b1;
                w_prescalerNext = '0;
            end else begin
                w_prescalerNext = r_prescaler + c_PRE_W'(1);
            end
        end
    end

    logic                    r_cpuEn;
    logic [c_STEP_CNT_W-1:0] r_stepCount;
    logic                    r_running;
    logic                    r_halted;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler <= '0;
            r_cpuEn     <= 1'b0;
            r_stepCount <= '0;
            r_running   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_prescaler <= w_prescalerNext;
            r_cpuEn     <= w_cpuEnNext;
            r_running   <= (w_nextState == ST_RUN);
            r_halted    <= (w_nextState == ST_HALT);
            if (r_cpuEn) begin
                r_stepCount <= r_stepCount + c_STEP_CNT_W'(1);
            end
        end
    end

    assign cpu_en     = r_cpuEn;
    assign step_count = r_stepCount;
    assign running    = r_running;
    assign halted     = r_halted;

    // The debounced level itself is only needed for the rising-edge pulse
    logic w_unusedStable;
    assign w_unusedStable = w_btnStable;

endmodule : cpu_step_controller
`default_nettype wire

// File: tb/tb_cpu_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_step_controller
// Description : Scoreboard bench for cpu_step_controller. Stimulus pushes the
//               expected (edge, step_count) of every cpu_en pulse; a monitor
//               pops and compares whenever cpu_en is seen high.
//               u0: DEBOUNCE_CYCLES=4, RUN_DIV=5. u1: DEBOUNCE_CYCLES=4,
//               RUN_DIV=1 for the continuous-run / counter-wrap case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_step_controller;

    typedef struct {
        int          edgeNo;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, btn0, sw0, halt0;
    logic        rst1, btn1, sw1, halt1;
    logic        cpuEn0, running0, halted0;
    logic        cpuEn1, running1, halted1;
    logic [15:0] stepCount0, stepCount1;

    int   edgeCnt = 0;
    int   checks  = 0;
    int   errors  = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    cpu_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(5)) u0 (
        .clk(clk), .rst(rst0), .btn_step(btn0), .sw_run(sw0), .halt(halt0),
        .cpu_en(cpuEn0), .step_count(stepCount0), .running(running0), .halted(halted0)
    );

    cpu_step_controller #(.DEBOUNCE_CYCLES(4), .RUN_DIV(1)) u1 (
        .clk(clk), .rst(rst1), .btn_step(btn1), .sw_run(sw1), .halt(halt1),
        .cpu_en(cpuEn1), .step_count(stepCount1), .running(running1), .halted(halted1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, req, edgeCnt);
        end
    endtask

    task automatic push0(input int e, input logic [15:0] c);
        exp_t x;
        x.edgeNo = e;
        x.cnt    = c;
        q0.push_back(x);
    endtask

    // Monitor: every observed pulse must match the head of the queue
    always @(negedge clk) begin
        exp_t e;
        if (cpuEn0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u0_unexpected_pulse: actual pulse at edge %0d required none", edgeCnt);
            end else begin
                e = q0.pop_front();
                check("u0_pulse_edge", edgeCnt, e.edgeNo);
                check("u0_pulse_count", {16'h0, stepCount0}, {16'h0, e.cnt});
            end
        end
        if (cpuEn1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL u1_unexpected_pulse: actual pulse at edge %0d required none", edgeCnt);
            end else begin
                e = q1.pop_front();
                check("u1_pulse_edge", edgeCnt, e.edgeNo);
                check("u1_pulse_count", {16'h0, stepCount1}, {16'h0, e.cnt});
            end
        end
    end

    initial begin
        int   base;
        exp_t x;
        rst0 = 1'b1; btn0 = 1'b1; sw0 = 1'b1; halt0 = 1'b0;
        rst1 = 1'b1; btn1 = 1'b0; sw1 = 1'b0; halt1 = 1'b0;

        // Reset held with inputs active: everything stays zero
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_cpu_en", {31'h0, cpuEn0}, 32'h0);
            check("reset_step_count", {16'h0, stepCount0}, 32'h0);
            check("reset_running", {31'h0, running0}, 32'h0);
            check("reset_halted", {31'h0, halted0}, 32'h0);
        end
        // Release reset with sw_run high: RUN from prescaler 0
        base = edgeCnt;
        rst0 = 1'b0;
        push0(base + 8, 16'd0);
        repeat (9) @(negedge clk);
        check("rst_run_queue_empty", q0.size(), 32'h0);
        check("rst_run_count", {16'h0, stepCount0}, 32'h1);
        // Reset mid-run
        rst0 = 1'b1; sw0 = 1'b0; btn0 = 1'b0;
        @(negedge clk);
        check("midrun_reset_count", {16'h0, stepCount0}, 32'h0);
        check("midrun_reset_running", {31'h0, running0}, 32'h0);
        rst0 = 1'b0;
        repeat (4) @(negedge clk);

        // Clean single press held 30 cycles then released
        base = edgeCnt;
        btn0 = 1'b1;
        push0(base + 7, 16'd0);
        repeat (30) @(negedge clk);
        btn0 = 1'b0;
        repeat (15) @(negedge clk);
        check("step_queue_empty", q0.size(), 32'h0);
        check("step_count_after_press", {16'h0, stepCount0}, 32'h1);

        // Bouncing button: toggles every 2 cycles, never stable long enough
        for (int i = 0; i < 6; i++) begin
            btn0 = 1'b1;
            repeat (2) @(negedge clk);
            btn0 = 1'b0;
            repeat (2) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check("bounce_count", {16'h0, stepCount0}, 32'h1);

        // Run mode: pulse every 5 cycles, step press ignored, then stop
        base = edgeCnt;
        sw0 = 1'b1;
        push0(base + 8, 16'd1);
        push0(base + 13, 16'd2);
        push0(base + 18, 16'd3);
        push0(base + 23, 16'd4);
        repeat (4) @(negedge clk);
        check("run_running", {31'h0, running0}, 32'h1);
        repeat (5) @(negedge clk);
        btn0 = 1'b1;
        repeat (10) @(negedge clk);
        btn0 = 1'b0;
        repeat (5) @(negedge clk);
        sw0 = 1'b0;
        repeat (3) @(negedge clk);
        check("run_stop_running", {31'h0, running0}, 32'h0);
        repeat (15) @(negedge clk);
        check("run_queue_empty", q0.size(), 32'h0);
        check("run_count", {16'h0, stepCount0}, 32'h5);

        // Halt on the prescaler terminal count suppresses the pulse
        base = edgeCnt;
        sw0 = 1'b1;
        push0(base + 8, 16'd5);
        repeat (12) @(negedge clk);
        halt0 = 1'b1;
        @(negedge clk);
        check("halt_halted", {31'h0, halted0}, 32'h1);
        check("halt_running", {31'h0, running0}, 32'h0);
        halt0 = 1'b0;
        sw0 = 1'b0;
        repeat (5) @(negedge clk);
        sw0 = 1'b1;
        repeat (5) @(negedge clk);
        btn0 = 1'b1;
        repeat (10) @(negedge clk);
        btn0 = 1'b0;
        repeat (10) @(negedge clk);
        check("halt_sticky", {31'h0, halted0}, 32'h1);
        check("halt_count", {16'h0, stepCount0}, 32'h6);
        check("halt_queue_empty", q0.size(), 32'h0);
        sw0 = 1'b0;
        rst0 = 1'b1;
        @(negedge clk);
        check("halt_reset_halted", {31'h0, halted0}, 32'h0);
        check("halt_reset_count", {16'h0, stepCount0}, 32'h0);
        rst0 = 1'b0;
        repeat (2) @(negedge clk);

        // RUN_DIV = 1: continuous enable, counter wraps 0xFFFF -> 0x0000
        base = edgeCnt;
        rst1 = 1'b0;
        sw1 = 1'b1;
        for (int k = 0; k <= 65536; k++) begin
            x.edgeNo = base + 4 + k;
            x.cnt    = 16'(k);
            q1.push_back(x);
        end
        repeat (65538) @(negedge clk);
        sw1 = 1'b0;
        repeat (10) @(negedge clk);
        check("wrap_queue_empty", q1.size(), 32'h0);
        check("wrap_count", {16'h0, stepCount1}, 32'h1);
        check("wrap_running", {31'h0, running1}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cpu_step_controller
`default_nettype wire
